// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared types for the RAM arbiter. It holds the RAM word,
//                the RAM status encoding, the arbiter state encoding and
//                helpers that map between source indices and CPU numbers.
//                Each CPU c owns two sources: 2c is the dcache, 2c+1 is
//                the icache.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   // ARB_ prefix keeps these distinct from the ramstate_t literal BUSY.
   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   function automatic int src_dcache(input int cpu);
      return 2 * cpu;
   endfunction

   function automatic int src_icache(input int cpu);
      return 2 * cpu + 1;
   endfunction

   function automatic int src_cpu(input int src);
      return src / 2;
   endfunction

   function automatic logic src_is_icache(input int src);
      return (src % 2) == 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter_if
//  Description : Bus bundle between the CPU caches, the arbiter and the RAM.
//                CPU side : iREN/iaddr, dREN/dWEN/daddr/dstore requests, and
//                           iwait/dwait/iload/dload responses.
//                RAM side : ramREN/ramWEN/ramaddr/ramstore towards the RAM,
//                           and ramstate/ramload back from it.
//                Status   : timeout_err (sticky).
//                The slave modport is the arbiter's view; the master modport
//                is the view of whatever drives the caches and the RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
   parameter int CPUS = 2
);
   import cpu_types_pkg::*;

   logic [CPUS-1:0] iREN;
   word_t           iaddr  [CPUS];
   logic [CPUS-1:0] dREN;
   logic [CPUS-1:0] dWEN;
   word_t           daddr  [CPUS];
   word_t           dstore [CPUS];
   ramstate_t       ramstate;
   word_t           ramload;
   logic            ramREN;
   logic            ramWEN;
   word_t           ramaddr;
   word_t           ramstore;
   logic [CPUS-1:0] iwait;
   logic [CPUS-1:0] dwait;
   word_t           iload  [CPUS];
   word_t           dload  [CPUS];
   logic            timeout_err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
      output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload,
             timeout_err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
      input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload,
             timeout_err
   );

endinterface
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin picker. It returns the first set
//                bit of i_req at or after i_ptr, wrapping modulo N.
//                i_req   : request vector, one bit per source
//                i_ptr   : search start index
//                o_grant : index of the selected source
//                o_valid : 1 when some request bit is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  wire logic [N-1:0]  i_req,
   input  wire logic [IW-1:0] i_ptr,
   output logic      [IW-1:0] o_grant,
   output logic               o_valid
);

   int w_idx;

   always_comb begin
      o_grant = '0;
      o_valid = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < N; k++) begin
         w_idx = (int'(i_ptr) + k) % N;
         if (!o_valid && i_req[w_idx]) begin
            o_grant = IW'(w_idx);
            o_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Round-robin arbiter that shares one RAM port among 2*CPUS
//                cache requesters (dcache = source 2c, icache = source 2c+1).
//                In IDLE it latches an owner. In BUSY it presents the owner's
//                request to the RAM until ACCESS, ERROR, a dropped request
//                or a timeout.
//                CLK         : clock, rising edge
//                RST         : synchronous active-high reset
//                bus (slave) : cache requests/responses, RAM strobes/status
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS    = 2,
   parameter int TIMEOUT = 255
) (
   input  wire logic     CLK,
   input  wire logic     RST,
   ram_arbiter_if.slave  bus
);

   localparam int        c_nsrc    = 2 * CPUS;
   localparam int        c_iw      = $clog2(c_nsrc);
   localparam int        c_cw      = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam logic [7:0] c_timeout = 8'(TIMEOUT);

   arb_state_t        r_state;
   logic [c_iw-1:0]   r_owner;
   logic [c_iw-1:0]   r_rr_ptr;
   logic [7:0]        r_busy_cnt;
   logic              r_timeout_err;

   logic [c_nsrc-1:0] w_req;
   logic [c_iw-1:0]   w_grant;
   logic              w_valid;
   logic [c_cw-1:0]   w_cpu;
   logic              w_owner_icache;
   logic              w_owner_active;
   logic              w_drive;
   logic              w_write;
   logic              w_release;
   logic [c_iw-1:0]   w_next_ptr;

   generate
      for (genvar c = 0; c < CPUS; c++) begin : g_src
         assign w_req[2*c]   = bus.dREN[c] | bus.dWEN[c];
         assign w_req[2*c+1] = bus.iREN[c];
         // Read data is broadcast; only the wait signal qualifies it.
         assign bus.iload[c] = bus.ramload;
         assign bus.dload[c] = bus.ramload;
         assign bus.dwait[c] = !(w_release && (r_owner == c_iw'(src_dcache(c))));
         assign bus.iwait[c] = !(w_release && (r_owner == c_iw'(src_icache(c))));
      end
   endgenerate

   rr_picker #(
      .N  (c_nsrc),
      .IW (c_iw)
   ) u_rr_picker (
      .i_req   (w_req),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_valid (w_valid)
   );

   // The RAM side is decoded from the current inputs so that a dropped
   // request removes the strobes in the same cycle. Holding RST masks
   // everything, so a reset during BUSY never releases a wait.
   always_comb begin
      w_cpu          = c_cw'(src_cpu(int'(r_owner)));
      w_owner_icache = src_is_icache(int'(r_owner));
      w_owner_active = w_owner_icache ? bus.iREN[w_cpu]
                                      : (bus.dREN[w_cpu] | bus.dWEN[w_cpu]);
      w_drive        = (r_state == ARB_BUSY) && w_owner_active && !RST;
      w_write        = w_drive && !w_owner_icache && bus.dWEN[w_cpu];
      w_release      = w_drive && (bus.ramstate == ACCESS);
      w_next_ptr     = (r_owner == c_iw'(c_nsrc - 1)) ? '0 : r_owner + c_iw'(1);
   end

   assign bus.ramREN      = w_drive && !w_write;
   assign bus.ramWEN      = w_write;
   assign bus.ramaddr     = !w_drive       ? '0 :
                            w_owner_icache ? bus.iaddr[w_cpu] : bus.daddr[w_cpu];
   assign bus.ramstore    = w_write ? bus.dstore[w_cpu] : '0;
   assign bus.timeout_err = r_timeout_err;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state       <= ARB_IDLE;
         r_owner       <= '0;
         r_rr_ptr      <= '0;
         r_busy_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_valid) begin
                  r_owner    <= w_grant;
                  r_busy_cnt <= '0;
                  r_state    <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (!w_owner_active) begin
                  // Abandoned by the requester: retry from the same pointer.
                  r_state <= ARB_IDLE;
               end else if ((bus.ramstate == ACCESS) || (bus.ramstate == ERROR)) begin
                  r_state  <= ARB_IDLE;
                  r_rr_ptr <= w_next_ptr;
               end else if (r_busy_cnt == c_timeout) begin
                  r_state       <= ARB_IDLE;
                  r_rr_ptr      <= w_next_ptr;
                  r_timeout_err <= 1'b1;
               end else begin
                  r_busy_cnt <= r_busy_cnt + 8'd1;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Directed self-checking bench for ram_arbiter (CPUS=2,
//                TIMEOUT=255). Inputs change 1 time unit after the rising
//                edge and outputs are compared after they settle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
   import cpu_types_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   ram_arbiter_if #(.CPUS(2)) bus ();

   ram_arbiter #(.CPUS(2), .TIMEOUT(255)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
      bus.ramstate = FREE; bus.ramload = '0;
      for (int c = 0; c < 2; c++) begin
         bus.iaddr[c] = '0; bus.daddr[c] = '0; bus.dstore[c] = '0;
      end
   endtask

   task automatic do_reset();
      clr();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clr();
      rst = 1'b1;
      bus.iREN = 2'b11; bus.dWEN = 2'b01; bus.daddr[0] = 32'h55; bus.ramstate = ACCESS;
      tick(); tick();
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.timeout_err} !== 7'b00_11_11_0) begin
         n_err++;
         $display("FAIL reset_ctl: got %b expected %b",
                  {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.timeout_err}, 7'b00_11_11_0);
      end
      n_cmp++;
      if ({bus.ramaddr, bus.ramstore} !== 64'h0) begin
         n_err++;
         $display("FAIL reset_bus: got %h expected %h", {bus.ramaddr, bus.ramstore}, 64'h0);
      end
      rst = 1'b0;
      clr();
   endtask

   task automatic test_single();
      do_reset();
      bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h100; bus.ramload = 32'hCAFEF00D;
      #1;
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 6'b00_11_11) begin
         n_err++;
         $display("FAIL single_latch: got %b expected %b", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 6'b00_11_11);
      end
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramaddr} !== {6'b10_11_11, 32'h100}) begin
         n_err++;
         $display("FAIL single_busy: got %h expected %h",
                  {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramaddr}, {6'b10_11_11, 32'h100});
      end
      tick();
      tick();
      bus.ramstate = ACCESS;
      #1;
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramaddr} !== {6'b10_10_11, 32'h100}) begin
         n_err++;
         $display("FAIL single_access: got %h expected %h",
                  {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramaddr}, {6'b10_10_11, 32'h100});
      end
      n_cmp++;
      if ({bus.iload[0], bus.iload[1], bus.dload[0], bus.dload[1]} !== {4{32'hCAFEF00D}}) begin
         n_err++;
         $display("FAIL single_load: got %h expected %h",
                  {bus.iload[0], bus.iload[1], bus.dload[0], bus.dload[1]}, {4{32'hCAFEF00D}});
      end
      tick();
      clr();
      #1;
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 6'b00_11_11) begin
         n_err++;
         $display("FAIL single_idle: got %b expected %b", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 6'b00_11_11);
      end
   endtask

   task automatic test_round_robin();
      word_t      addr_tab [4];
      int         order [5];
      logic [1:0] exp_i, exp_d;
      int         s;
      addr_tab = '{32'h1000, 32'h1100, 32'h2000, 32'h2100};
      order    = '{0, 1, 2, 3, 0};
      do_reset();
      bus.dREN = 2'b11; bus.iREN = 2'b11;
      bus.daddr[0] = 32'h1000; bus.iaddr[0] = 32'h1100;
      bus.daddr[1] = 32'h2000; bus.iaddr[1] = 32'h2100;
      bus.ramstate = ACCESS;
      for (int g = 0; g < 5; g++) begin
         s = order[g];
         exp_i = 2'b11; exp_d = 2'b11;
         if (s % 2 == 1) exp_i[s/2] = 1'b0;
         else            exp_d[s/2] = 1'b0;
         tick();
         n_cmp++;
         if (bus.ramaddr !== addr_tab[s]) begin
            n_err++;
            $display("FAIL rr_addr grant %0d: got %h expected %h", g, bus.ramaddr, addr_tab[s]);
         end
         n_cmp++;
         if ({bus.ramREN, bus.iwait, bus.dwait} !== {1'b1, exp_i, exp_d}) begin
            n_err++;
            $display("FAIL rr_wait grant %0d: got %b expected %b", g, {bus.ramREN, bus.iwait, bus.dwait}, {1'b1, exp_i, exp_d});
         end
         tick();
         n_cmp++;
         if ({bus.ramREN, bus.iwait, bus.dwait} !== 5'b0_11_11) begin
            n_err++;
            $display("FAIL rr_idle grant %0d: got %b expected %b", g, {bus.ramREN, bus.iwait, bus.dwait}, 5'b0_11_11);
         end
      end
      clr();
   endtask

   task automatic test_write();
      do_reset();
      bus.dREN[1] = 1'b1; bus.dWEN[1] = 1'b1;
      bus.daddr[1] = 32'h2000; bus.dstore[1] = 32'hDEADBEEF;
      bus.ramstate = BUSY; bus.ramload = 32'h12345678;
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 6'b01_11_11) begin
         n_err++;
         $display("FAIL write_ctl: got %b expected %b", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 6'b01_11_11);
      end
      n_cmp++;
      if ({bus.ramaddr, bus.ramstore} !== {32'h2000, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL write_bus: got %h expected %h", {bus.ramaddr, bus.ramstore}, {32'h2000, 32'hDEADBEEF});
      end
      bus.ramstate = ACCESS;
      #1;
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.dload[1]} !== {6'b01_11_01, 32'h12345678}) begin
         n_err++;
         $display("FAIL write_access: got %h expected %h",
                  {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.dload[1]}, {6'b01_11_01, 32'h12345678});
      end
      tick();
      clr();
      #1;
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramstore} !== {6'b00_11_11, 32'h0}) begin
         n_err++;
         $display("FAIL write_idle: got %h expected %h",
                  {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramstore}, {6'b00_11_11, 32'h0});
      end
   endtask

   task automatic test_error();
      do_reset();
      bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h700;
      bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h710;
      bus.ramstate = ERROR;
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.iwait, bus.dwait, bus.ramaddr} !== {5'b1_11_11, 32'h700}) begin
         n_err++;
         $display("FAIL error_busy: got %h expected %h", {bus.ramREN, bus.iwait, bus.dwait, bus.ramaddr}, {5'b1_11_11, 32'h700});
      end
      tick();
      bus.ramstate = ACCESS;
      #1;
      n_cmp++;
      if ({bus.ramREN, bus.iwait, bus.dwait} !== 5'b0_11_11) begin
         n_err++;
         $display("FAIL error_idle: got %b expected %b", {bus.ramREN, bus.iwait, bus.dwait}, 5'b0_11_11);
      end
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.iwait, bus.dwait, bus.ramaddr} !== {5'b1_10_11, 32'h710}) begin
         n_err++;
         $display("FAIL error_next: got %h expected %h", {bus.ramREN, bus.iwait, bus.dwait, bus.ramaddr}, {5'b1_10_11, 32'h710});
      end
      tick();
      clr();
   endtask

   task automatic test_drop();
      do_reset();
      bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h300; bus.iaddr[0] = 32'h310;
      bus.ramstate = BUSY;
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 6'b10_11_11) begin
         n_err++;
         $display("FAIL drop_busy: got %b expected %b", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 6'b10_11_11);
      end
      bus.dREN[0] = 1'b0;
      bus.ramstate = ACCESS;
      #1;
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 6'b00_11_11) begin
         n_err++;
         $display("FAIL drop_cycle: got %b expected %b", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 6'b00_11_11);
      end
      tick();
      bus.dREN[0] = 1'b1; bus.iREN[0] = 1'b1;
      #1;
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 6'b00_11_11) begin
         n_err++;
         $display("FAIL drop_idle: got %b expected %b", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 6'b00_11_11);
      end
      // Pointer still at 0, so the dcache of CPU 0 wins over its icache.
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.iwait, bus.dwait, bus.ramaddr} !== {5'b1_11_10, 32'h300}) begin
         n_err++;
         $display("FAIL drop_ptr: got %h expected %h", {bus.ramREN, bus.iwait, bus.dwait, bus.ramaddr}, {5'b1_11_10, 32'h300});
      end
      tick();
      clr();
   endtask

   task automatic test_timeout();
      int bad_cycle;
      bad_cycle = -1;
      do_reset();
      bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h400;
      bus.ramstate = BUSY;
      tick();
      for (int i = 0; i < 255; i++) begin
         if (bad_cycle < 0 && {bus.ramREN, bus.iwait, bus.dwait, bus.timeout_err} !== 6'b1_11_11_0)
            bad_cycle = i;
         tick();
      end
      n_cmp++;
      if (bad_cycle !== -1) begin
         n_err++;
         $display("FAIL timeout_hold: got deviation at busy cycle %0d expected none", bad_cycle);
      end
      n_cmp++;
      if ({bus.ramREN, bus.iwait, bus.dwait, bus.timeout_err} !== 6'b1_11_11_0) begin
         n_err++;
         $display("FAIL timeout_last: got %b expected %b", {bus.ramREN, bus.iwait, bus.dwait, bus.timeout_err}, 6'b1_11_11_0);
      end
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.iwait, bus.dwait, bus.timeout_err} !== 6'b0_11_11_1) begin
         n_err++;
         $display("FAIL timeout_abort: got %b expected %b", {bus.ramREN, bus.iwait, bus.dwait, bus.timeout_err}, 6'b0_11_11_1);
      end
      bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h500; bus.ramstate = ACCESS;
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.iwait, bus.dwait, bus.timeout_err, bus.ramaddr} !== {6'b1_11_10_1, 32'h500}) begin
         n_err++;
         $display("FAIL timeout_next: got %h expected %h",
                  {bus.ramREN, bus.iwait, bus.dwait, bus.timeout_err, bus.ramaddr}, {6'b1_11_10_1, 32'h500});
      end
      tick();
      clr();
      tick();
      n_cmp++;
      if (bus.timeout_err !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_sticky: got %b expected %b", bus.timeout_err, 1'b1);
      end
      do_reset();
      n_cmp++;
      if (bus.timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_clear: got %b expected %b", bus.timeout_err, 1'b0);
      end
   endtask

   task automatic test_reset_busy();
      do_reset();
      bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h600; bus.iaddr[0] = 32'h610;
      bus.dstore[0] = 32'h11; bus.ramstate = BUSY;
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramaddr} !== {6'b10_11_11, 32'h600}) begin
         n_err++;
         $display("FAIL rstbusy_busy: got %h expected %h",
                  {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramaddr}, {6'b10_11_11, 32'h600});
      end
      tick();
      rst = 1'b1;
      bus.ramstate = ACCESS;
      #1;
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 6'b00_11_11) begin
         n_err++;
         $display("FAIL rstbusy_same: got %b expected %b", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 6'b00_11_11);
      end
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramaddr, bus.ramstore} !== {6'b00_11_11, 64'h0}) begin
         n_err++;
         $display("FAIL rstbusy_edge: got %h expected %h",
                  {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramaddr, bus.ramstore}, {6'b00_11_11, 64'h0});
      end
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.ramWEN, bus.ramaddr} !== {2'b00, 32'h0}) begin
         n_err++;
         $display("FAIL rstbusy_held: got %h expected %h", {bus.ramREN, bus.ramWEN, bus.ramaddr}, {2'b00, 32'h0});
      end
      rst = 1'b0;
      bus.iREN[0] = 1'b1;
      // Pointer was reset to 0, so source 0 wins over source 1.
      tick();
      n_cmp++;
      if ({bus.ramREN, bus.iwait, bus.dwait, bus.ramaddr} !== {5'b1_11_10, 32'h600}) begin
         n_err++;
         $display("FAIL rstbusy_ptr: got %h expected %h", {bus.ramREN, bus.iwait, bus.dwait, bus.ramaddr}, {5'b1_11_10, 32'h600});
      end
      tick();
      clr();
   endtask

   initial begin
      clr();
      test_reset();
      test_single();
      test_round_robin();
      test_write();
      test_error();
      test_drop();
      test_timeout();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
